axis_pkt_arbiter: RTL
=====================

Name: axis_pkt_arbiter

Overview:
- Packet-level round-robin arbiter that shares one 64-bit AXI-Stream datapath between NUM_PORTS AXIS masters.
- Feeds the single downstream AXIS slave, typically the packet sink/monitor in the pkt_tm bench or a MAC TX path.
- Once a port is granted, the grant is held until that port's tlast beat has been accepted, so packets never interleave.
- Output is registered. The forwarding source index is carried on m_axis_tid.

Parameters:
- NUM_PORTS, 4, number of upstream AXIS masters (2..8).
- DATA_W, 64, tdata width in bits (multiple of 8).
- KEEP_W, DATA_W/8, tkeep width.
- ID_W, 2, width of m_axis_tid (>= clog2(NUM_PORTS)).
- CNT_W, 32, width of the forwarded-packet counter.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  NUM_PORTS*DATA_W  port p in bits [p*DATA_W +: DATA_W].
- s_axis_tkeep  in  NUM_PORTS*KEEP_W  per-port byte enables, same packing.
- s_axis_tvalid  in  NUM_PORTS  per-port valid.
- s_axis_tlast  in  NUM_PORTS  per-port end of packet.
- s_axis_tready  out  NUM_PORTS  per-port ready.
- m_axis_tdata  out  DATA_W  forwarded data.
- m_axis_tkeep  out  KEEP_W  forwarded byte enables.
- m_axis_tvalid  out  1  output valid.
- m_axis_tlast  out  1  output end of packet.
- m_axis_tid  out  ID_W  index of the source port of the current beat.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high while in XFER.
- pkt_cnt  out  CNT_W  number of packets whose tlast beat was accepted at the output; wraps modulo 2^CNT_W.

Behaviour:
- Reset values: state=IDLE; last_grant=NUM_PORTS-1, so port 0 wins first; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata/tkeep/tlast/tid=0; busy=0; pkt_cnt=0.
- Reset mid-packet: the transfer is abandoned and the output register is cleared. No recovery of the partial packet.
- IDLE:
  - All s_axis_tready are 0.
  - If any s_axis_tvalid is high, select the first requesting port searching last_grant+1, last_grant+2, ... modulo NUM_PORTS.
  - Register the selection as grant and move to XFER on the next edge.
  - No request: stay in IDLE.
  - Requests are sampled only in IDLE. A port that raises valid while another port is in XFER waits for the next arbitration.
- XFER:
  - s_axis_tready[grant] = (!m_axis_tvalid || m_axis_tready). All other ready bits are 0.
  - Input beat accepted (valid & ready on grant): next edge loads m_axis_tdata/tkeep/tlast from that port, sets m_axis_tid=grant and m_axis_tvalid=1.
  - Output accepted with no new input beat: m_axis_tvalid drops to 0.
  - Throughput: 1 beat/clk while both sides stay ready. Latency from input acceptance to m_axis_tvalid is 1 clk.
  - Accepted input beat with tlast=1: last_grant<=grant, state<=IDLE on the same edge. The output register still drains that beat.
- Arbitration bubble: exactly one cycle with no input accepted between consecutive packets.
- Granted port drops tvalid mid-packet: grant is held, the arbiter waits indefinitely, and no other port is served.
- Downstream backpressure (m_axis_tready=0 with m_axis_tvalid=1): output register holds its contents stable and s_axis_tready[grant]=0.
- tkeep is passed through unmodified, including all-zero tkeep beats. The block does not interpret tkeep.
- pkt_cnt increments on each edge where m_axis_tvalid & m_axis_tready & m_axis_tlast.
- Single-beat packet (tlast on the first beat): XFER lasts one accepted beat, then back to IDLE.
- busy = (state==XFER).

Test Plan:
- Single port:
  - Stimulus: port 2 sends a 3-beat packet, tkeep FF,FF,0F, m_axis_tready=1.
  - Required: output beats follow 1 clk after acceptance; m_axis_tid=2 on all three beats; tlast only on beat 3; pkt_cnt=1; busy high from grant until tlast accepted.
- Round robin:
  - Stimulus: all 4 ports continuously offer 2-beat packets after reset.
  - Required: grant order 0,1,2,3,0,1; one idle input cycle between packets; no interleaving on m_axis_tid within a packet.
- Backpressure:
  - Stimulus: port 1 sends a 4-beat packet while m_axis_tready toggles 1,0,0,1,...
  - Required: data and tkeep stable while stalled; s_axis_tready[1]=0 during stalls; beats emerge in order with none lost or duplicated.
- Hold under bubble:
  - Stimulus: port 0 drops tvalid for 5 clk mid-packet while port 3 requests.
  - Required: s_axis_tready[3] stays 0 until port 0's tlast is accepted; port 3 is granted next.
- Reset mid-packet:
  - Stimulus: assert rst for 1 clk during beat 2 of a port 1 packet.
  - Required: next cycle m_axis_tvalid=0, pkt_cnt=0, busy=0; a subsequent request from ports 1 and 0 is granted to port 0 first.
- Counter wrap:
  - Stimulus: CNT_W=4, send 17 single-beat packets.
  - Required: pkt_cnt=1.

Source files
------------

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: NUM_PORTS AXI-Stream masters share one registered output.
// A grant is held until the granted port's tlast beat is accepted, so packets never interleave.
module axis_pkt_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 64,
  parameter int KEEP_W    = DATA_W/8,
  parameter int ID_W      = 2,
  parameter int CNT_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]        s_axis_tlast,
  output logic [NUM_PORTS-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]           m_axis_tdata,
  output logic [KEEP_W-1:0]           m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  output logic [ID_W-1:0]             m_axis_tid,
  input  logic                        m_axis_tready,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkt_cnt
);
  typedef enum logic {IDLE, XFER} state_t;

  state_t                           state, state_nx;
  logic [ID_W-1:0]                  grant, last_grant, sel;
  logic                             found, out_ready, accept;
  logic [NUM_PORTS-1:0][DATA_W-1:0] data_v;
  logic [NUM_PORTS-1:0][KEEP_W-1:0] keep_v;

  assign data_v    = s_axis_tdata;
  assign keep_v    = s_axis_tkeep;
  assign out_ready = !m_axis_tvalid || m_axis_tready;
  assign accept    = (state == XFER) && s_axis_tvalid[grant] && out_ready;
  assign busy      = (state == XFER);

  // Round-robin search starts one past the last granted port.
  always_comb begin
    sel   = last_grant;
    found = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!found && s_axis_tvalid[(int'(last_grant) + i) % NUM_PORTS]) begin
        sel   = ID_W'((int'(last_grant) + i) % NUM_PORTS);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (found) state_nx = XFER;
      XFER:    if (accept && s_axis_tlast[grant]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdy
    assign s_axis_tready[p] = (state == XFER) && (grant == ID_W'(p)) && out_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= ID_W'(NUM_PORTS - 1);
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      pkt_cnt       <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) grant <= sel;
      if (accept) begin
        m_axis_tdata  <= data_v[grant];
        m_axis_tkeep  <= keep_v[grant];
        m_axis_tlast  <= s_axis_tlast[grant];
        m_axis_tid    <= grant;
        m_axis_tvalid <= 1'b1;
        if (s_axis_tlast[grant]) last_grant <= grant;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_cnt <= pkt_cnt + CNT_W'(1);
    end
  end
endmodule
